adpll_ctrl_5bit: RTL and testbench
==================================

# adpll_ctrl_5bit

Calibration and gain-scheduling controller for the 5-bit ADPLL. After a start request it holds the loop in reset and coarse-tunes `dco_offset` by successive approximation. It does this by comparing synchronized feedback-clock edges against reference-clock edges over a fixed window. It then releases the loop with wide acquisition gains, detects lock from the loop-filter output, and switches to narrow tracking gains, falling back to acquisition on loss of lock.

## Interface
Parameters:
- `WIN` (default 16): reference periods per calibration measurement; 1..127.
- `SETTLE` (default 8): `clk` cycles the DCO settles after each trial offset; 1..255.
- `LOCK_CNT` (default 8): consecutive in-threshold reference samples needed to declare lock; 1..255.
- `LOSS_CNT` (default 4): consecutive out-of-threshold reference samples needed to declare loss of lock; 1..255.
- `OFFSET_UP_FAST` (default 1): 1 means a larger `dco_offset` gives a higher DCO frequency; 0 means the inverse.

Ports:
- `clk` in 1: system clock, the same `clk` as the ADPLL core.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request to start calibration; accepted only in IDLE.
- `clk_ref` in 1: reference clock, asynchronous to `clk`.
- `fb_clk` in 1: ADPLL feedback clock, asynchronous to `clk`.
- `filter_out` in 5: loop-filter magnitude.
- `filter_sign` in 1: loop-filter sign; used for status only.
- `alpha_acq`, `beta_acq` in 5 each: acquisition gains.
- `alpha_trk`, `beta_trk` in 5 each: tracking gains.
- `lock_thresh` in 5: lock window on `|filter_out|`.
- `dco_offset` out 5: trial or calibrated DCO offset sent to the core.
- `alpha_var`, `beta_var` out 5 each: gains sent to the loop filter.
- `pll_rst` out 1: reset for the tdc, filter, dco and divider; ORed externally with `reset`.
- `cal_done` out 1: set when calibration completes.
- `locked` out 1: lock indicator.
- `state` out 3: encoding IDLE=0, CAL_SET=1, CAL_MEAS=2, ACQ=3, TRACK=4.

## Operation
- Synchronization: `clk_ref` and `fb_clk` each pass through a 2-flop synchronizer followed by a rising-edge detector. This produces one-cycle pulses `ref_p` and `fb_p`.
- IDLE:
  - Outputs: `pll_rst`=1, `locked`=0.
  - Hold `dco_offset`, `cal_done` and the gains at their current values.
  - On `start`: clear `cal_done`, set bit index to 4, set trial to 5'b10000, go to CAL_SET.
- CAL_SET:
  - `pll_rst`=1 and `dco_offset`=trial.
  - Count `SETTLE` cycles, then go to CAL_MEAS.
- CAL_MEAS:
  - Wait for the first `ref_p`, which arms the measurement; this first pulse is not counted.
  - After arming, count `ref_p` into `rcnt` and `fb_p` into `fcnt`. `fcnt` is 8 bits and saturates at 255.
  - When `rcnt` reaches `WIN`, the DCO is "slow" if `fcnt` <= `WIN`. The equal case counts as slow.
  - Keep the current bit if (slow XNOR `OFFSET_UP_FAST`); otherwise clear it.
  - If bit index > 0: decrement the index, set the next lower bit in the trial, and go to CAL_SET.
  - If bit index = 0: latch the final `dco_offset`, set `cal_done`=1, and go to ACQ.
- ACQ:
  - `pll_rst`=0; `alpha_var`/`beta_var` = `alpha_acq`/`beta_acq`.
  - On each `ref_p`, sample `filter_out`. If `filter_out` <= `lock_thresh`, increment the in-window counter; otherwise clear it.
  - When the counter reaches `LOCK_CNT`, go to TRACK.
- TRACK:
  - `locked`=1; gains = `alpha_trk`/`beta_trk`.
  - On each `ref_p`, if `filter_out` > `lock_thresh`, increment the out-window counter; otherwise clear it.
  - When the counter reaches `LOSS_CNT`, clear `locked`, clear both counters, and go to ACQ with acquisition gains.
- `start` outside IDLE is ignored. There is no exit from ACQ/TRACK other than `reset`.
- Simultaneous `ref_p` and `fb_p` in the same cycle: both are counted.

## Timing
- Reset values (asynchronous):
  - `state`=IDLE, `pll_rst`=1, `dco_offset`=0, `alpha_var`=0, `beta_var`=0, `cal_done`=0, `locked`=0.
  - All counters and synchronizers = 0.
- Asserting `reset` mid-operation aborts immediately to these values. After `reset` deasserts, the block waits for a new `start`.
- All outputs are registered.
- `start` sampled in cycle N: `state`=CAL_SET and `dco_offset`=16 in cycle N+1.
- Input edge to `ref_p`/`fb_p`: 3 `clk` cycles.
- Per calibration bit: `SETTLE` cycles + arming wait + `WIN` reference periods. Total calibration time is 5 × that.
- Final CAL_MEAS decision to ACQ: 1 cycle. `pll_rst` falls, `cal_done` rises and the gains switch in that same cycle.
- Lock: `locked` rises 1 cycle after the `LOCK_CNT`-th qualifying `ref_p`, together with the switch to tracking gains. Loss of lock behaves symmetrically.

## Test plan
- Reset: assert `reset` at random times, including mid-CAL_MEAS. Required: all outputs at their reset values within the same cycle; `state`=0; `pll_rst`=1.
- SAR calibration: behavioural DCO where the fb frequency rises with offset and the target code is 13 (`OFFSET_UP_FAST`=1, `WIN`=16). Required: trial sequence 16 → 8 → 12 → 14 → 13, final `dco_offset`=13, `cal_done`=1, ACQ entered.
- Inverted polarity: `OFFSET_UP_FAST`=0 with a mirrored DCO model. Required: final offset 18.
- Lock: after calibration, drive `filter_out`=2 with `lock_thresh`=3 for 8 ref edges. Required: `locked`=1 after the 8th edge, `alpha_var`=`alpha_trk`. With 7 good edges then 1 bad edge: no lock.
- Loss of lock: in TRACK, drive `filter_out`=9 for 4 ref edges. Required: `locked`=0, ACQ entered, acquisition gains restored. With 3 bad edges then 1 good edge: stays in TRACK.
- `start` pulsed during CAL_MEAS, ACQ and TRACK: required no effect. `fb_clk` far faster than `clk_ref`: required `fcnt` saturates at 255 with no wrap, and the bit is cleared (when `OFFSET_UP_FAST`=1).

Source files
------------

// File: rtl/adpll_ctrl_5bit.sv
// Calibration and gain-scheduling controller for the 5-bit ADPLL: SAR coarse
// tuning of the DCO offset, then acquisition/tracking gain control with lock detect.
module adpll_ctrl_5bit #(
  parameter int WIN            = 16,
  parameter int SETTLE         = 8,
  parameter int LOCK_CNT       = 8,
  parameter int LOSS_CNT       = 4,
  parameter int OFFSET_UP_FAST = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       clk_ref,
  input  logic       fb_clk,
  input  logic [4:0] filter_out,
  input  logic       filter_sign,
  input  logic [4:0] alpha_acq,
  input  logic [4:0] beta_acq,
  input  logic [4:0] alpha_trk,
  input  logic [4:0] beta_trk,
  input  logic [4:0] lock_thresh,
  output logic [4:0] dco_offset,
  output logic [4:0] alpha_var,
  output logic [4:0] beta_var,
  output logic       pll_rst,
  output logic       cal_done,
  output logic       locked,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CAL_SET  = 3'd1,
    CAL_MEAS = 3'd2,
    ACQ      = 3'd3,
    TRACK    = 3'd4
  } state_t;

  localparam logic [6:0] WIN_C       = 7'(WIN);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [7:0] LOCK_C      = 8'(LOCK_CNT);
  localparam logic [7:0] LOSS_C      = 8'(LOSS_CNT);
  localparam bit         UP_FAST     = (OFFSET_UP_FAST != 0);

  state_t     state_q;
  logic [2:0] ref_sync, fb_sync;
  logic       ref_p, fb_p;
  logic [7:0] settle_cnt;
  logic       armed;
  logic [6:0] rcnt;
  logic [7:0] fcnt;
  logic [2:0] bit_idx;
  logic [4:0] trial;
  logic [7:0] in_cnt, out_cnt;

  logic [6:0] rcnt_nxt;
  logic [7:0] fcnt_nxt;
  logic       slow, keep, in_good;
  logic [4:0] bit_mask, trial_dec, next_trial;
  logic [7:0] in_nxt, out_nxt;

  // The loop-filter sign is carried for status only and does not steer control.
  logic unused_status;
  assign unused_status = filter_sign;

  assign state = state_q;
  assign ref_p = ref_sync[1] & ~ref_sync[2];
  assign fb_p  = fb_sync[1]  & ~fb_sync[2];

  // Both clocks are asynchronous to clk: two flops to resolve metastability, a third for edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_sync <= 3'b000;
      fb_sync  <= 3'b000;
    end else begin
      ref_sync <= {ref_sync[1:0], clk_ref};
      fb_sync  <= {fb_sync[1:0], fb_clk};
    end
  end

  always_comb begin
    rcnt_nxt   = rcnt + {6'd0, ref_p};
    fcnt_nxt   = (fb_p && fcnt != 8'hFF) ? fcnt + 8'd1 : fcnt;
    slow       = (fcnt_nxt <= {1'b0, WIN_C});
    keep       = (slow == UP_FAST);
    bit_mask   = 5'b00001 << bit_idx;
    trial_dec  = keep ? trial : (trial & ~bit_mask);
    next_trial = trial_dec | (bit_mask >> 1);
    in_good    = (filter_out <= lock_thresh);
    in_nxt     = in_cnt + 8'd1;
    out_nxt    = out_cnt + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pll_rst    <= 1'b1;
      dco_offset <= 5'd0;
      alpha_var  <= 5'd0;
      beta_var   <= 5'd0;
      cal_done   <= 1'b0;
      locked     <= 1'b0;
      settle_cnt <= 8'd0;
      armed      <= 1'b0;
      rcnt       <= 7'd0;
      fcnt       <= 8'd0;
      bit_idx    <= 3'd0;
      trial      <= 5'd0;
      in_cnt     <= 8'd0;
      out_cnt    <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          pll_rst <= 1'b1;
          locked  <= 1'b0;
          if (start) begin
            cal_done   <= 1'b0;
            bit_idx    <= 3'd4;
            trial      <= 5'b10000;
            dco_offset <= 5'b10000;
            settle_cnt <= 8'd0;
            state_q    <= CAL_SET;
          end
        end
        CAL_SET: begin
          pll_rst    <= 1'b1;
          dco_offset <= trial;
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= 8'd0;
            armed      <= 1'b0;
            rcnt       <= 7'd0;
            fcnt       <= 8'd0;
            state_q    <= CAL_MEAS;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        // The first reference edge only opens the window so it spans whole reference periods.
        CAL_MEAS: begin
          if (!armed) begin
            if (ref_p) armed <= 1'b1;
          end else begin
            rcnt <= rcnt_nxt;
            fcnt <= fcnt_nxt;
            if (rcnt_nxt == WIN_C) begin
              if (bit_idx != 3'd0) begin
                bit_idx    <= bit_idx - 3'd1;
                trial      <= next_trial;
                dco_offset <= next_trial;
                state_q    <= CAL_SET;
              end else begin
                trial      <= trial_dec;
                dco_offset <= trial_dec;
                cal_done   <= 1'b1;
                pll_rst    <= 1'b0;
                alpha_var  <= alpha_acq;
                beta_var   <= beta_acq;
                in_cnt     <= 8'd0;
                out_cnt    <= 8'd0;
                state_q    <= ACQ;
              end
            end
          end
        end
        ACQ: begin
          pll_rst   <= 1'b0;
          locked    <= 1'b0;
          alpha_var <= alpha_acq;
          beta_var  <= beta_acq;
          if (ref_p) begin
            if (!in_good) begin
              in_cnt <= 8'd0;
            end else if (in_nxt == LOCK_C) begin
              in_cnt    <= 8'd0;
              out_cnt   <= 8'd0;
              locked    <= 1'b1;
              alpha_var <= alpha_trk;
              beta_var  <= beta_trk;
              state_q   <= TRACK;
            end else begin
              in_cnt <= in_nxt;
            end
          end
        end
        TRACK: begin
          pll_rst   <= 1'b0;
          locked    <= 1'b1;
          alpha_var <= alpha_trk;
          beta_var  <= beta_trk;
          if (ref_p) begin
            if (in_good) begin
              out_cnt <= 8'd0;
            end else if (out_nxt == LOSS_C) begin
              in_cnt    <= 8'd0;
              out_cnt   <= 8'd0;
              locked    <= 1'b0;
              alpha_var <= alpha_acq;
              beta_var  <= beta_acq;
              state_q   <= ACQ;
            end else begin
              out_cnt <= out_nxt;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adpll_ctrl_5bit.sv
// Bench for adpll_ctrl_5bit: behavioural DCOs close the calibration loop for both
// offset polarities, then table and random filter sequences exercise lock/loss.
`timescale 1ns/100ps
module tb_adpll_ctrl_5bit;

  localparam int WIN      = 16;
  localparam int LOCK_CNT = 8;
  localparam int LOSS_CNT = 4;
  localparam int REF_NOM  = 200;

  logic       clk = 1'b0;
  logic       reset, start, clk_ref, fb_a, fb_b, filter_sign;
  logic [4:0] filter_out, lock_thresh, alpha_acq, beta_acq, alpha_trk, beta_trk;
  logic [4:0] off_a, alpha_a, beta_a, off_b, alpha_b, beta_b;
  logic       pll_rst_a, cal_done_a, locked_a, pll_rst_b, cal_done_b, locked_b;
  logic [2:0] state_a, state_b;

  int  ref_half = REF_NOM / 2;
  bit  fb_force = 1'b0;
  int  checks = 0;
  int  failures = 0;

  adpll_ctrl_5bit #(.OFFSET_UP_FAST(1)) dut (
    .clk(clk), .reset(reset), .start(start), .clk_ref(clk_ref), .fb_clk(fb_a),
    .filter_out(filter_out), .filter_sign(filter_sign),
    .alpha_acq(alpha_acq), .beta_acq(beta_acq), .alpha_trk(alpha_trk), .beta_trk(beta_trk),
    .lock_thresh(lock_thresh), .dco_offset(off_a), .alpha_var(alpha_a), .beta_var(beta_a),
    .pll_rst(pll_rst_a), .cal_done(cal_done_a), .locked(locked_a), .state(state_a)
  );

  adpll_ctrl_5bit #(.OFFSET_UP_FAST(0)) dut_inv (
    .clk(clk), .reset(reset), .start(start), .clk_ref(clk_ref), .fb_clk(fb_b),
    .filter_out(filter_out), .filter_sign(filter_sign),
    .alpha_acq(alpha_acq), .beta_acq(beta_acq), .alpha_trk(alpha_trk), .beta_trk(beta_trk),
    .lock_thresh(lock_thresh), .dco_offset(off_b), .alpha_var(alpha_b), .beta_var(beta_b),
    .pll_rst(pll_rst_b), .cal_done(cal_done_b), .locked(locked_b), .state(state_b)
  );

  always #5 clk = ~clk;

  initial begin
    clk_ref = 1'b0;
    #2.3;
    forever begin
      #(ref_half);
      clk_ref = ~clk_ref;
    end
  end

  // DCO period in ns falls linearly with the code; codes up to 13 run slower than the reference.
  function automatic int dcoPeriod(input int code);
    int p;
    p = 740 - 40 * code;
    return (p < 60) ? 60 : p;
  endfunction

  real ph_a = 0.0;
  real ph_b = 0.3;
  initial begin
    fb_a = 1'b0;
    fb_b = 1'b0;
    #0.5;
    forever begin
      ph_a = ph_a + 1.0 / real'(fb_force ? 60 : dcoPeriod(int'(off_a)));
      ph_b = ph_b + 1.0 / real'(fb_force ? 60 : dcoPeriod(32 - int'(off_b)));
      if (ph_a >= 1.0) ph_a = ph_a - 1.0;
      if (ph_b >= 1.0) ph_b = ph_b - 1.0;
      fb_a = (ph_a < 0.5);
      fb_b = (ph_b < 0.5);
      #1;
    end
  end

  function automatic bit dcoFast(input int code, input bit up_fast);
    int eff;
    eff = up_fast ? code : 32 - code;
    return (WIN * REF_NOM) / dcoPeriod(eff) > WIN;
  endfunction

  // Binary search over the code: idx 0..4 gives the trial tried at that step, 5 the result.
  function automatic int sarStep(input bit up_fast, input int idx);
    int code;
    int trial;
    bit keep;
    code = 0;
    for (int b = 4; b >= 0; b--) begin
      trial = code | (1 << b);
      if (idx == 4 - b) return trial;
      keep = up_fast ? !dcoFast(trial, up_fast) : dcoFast(trial, up_fast);
      if (keep) code = trial;
    end
    return code;
  endfunction

  int         trials_a[$];
  int         trials_b[$];
  logic [2:0] prev_a = 3'd0;
  logic [2:0] prev_b = 3'd0;
  always @(negedge clk) begin
    if (state_a == 3'd1 && prev_a != 3'd1) trials_a.push_back(int'(off_a));
    if (state_b == 3'd1 && prev_b != 3'd1) trials_b.push_back(int'(off_b));
    prev_a = state_a;
    prev_b = state_b;
  end

  typedef struct {
    logic [4:0] fo;
    logic [4:0] th;
    bit         pulse;
    int         exp_state;
    bit         exp_locked;
  } vec_t;
  vec_t vecs[$];

  function automatic void addVec(input int fo, input int th, input bit pulse,
                                 input int st, input bit lk);
    vec_t v;
    v.fo = 5'(fo);
    v.th = 5'(th);
    v.pulse = pulse;
    v.exp_state = st;
    v.exp_locked = lk;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_state"}, int'(state_a), 0);
    checkOutput({tag, "_pll_rst"}, int'(pll_rst_a), 1);
    checkOutput({tag, "_offset"}, int'(off_a), 0);
    checkOutput({tag, "_alpha"}, int'(alpha_a), 0);
    checkOutput({tag, "_beta"}, int'(beta_a), 0);
    checkOutput({tag, "_cal_done"}, int'(cal_done_a), 0);
    checkOutput({tag, "_locked"}, int'(locked_a), 0);
    checkOutput({tag, "_inv_state"}, int'(state_b), 0);
  endtask

  task automatic checkLoop(input string tag, input int exp_state, input bit exp_locked);
    checkOutput({tag, "_state"}, int'(state_a), exp_state);
    checkOutput({tag, "_locked"}, int'(locked_a), int'(exp_locked));
    checkOutput({tag, "_alpha"}, int'(alpha_a), int'(exp_state == 4 ? alpha_trk : alpha_acq));
    checkOutput({tag, "_beta"}, int'(beta_a), int'(exp_state == 4 ? beta_trk : beta_acq));
    checkOutput({tag, "_pll_rst"}, int'(pll_rst_a), 0);
  endtask

  task automatic pulseStart();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic waitState(input int target, input int max_cycles, input string name);
    int n;
    n = 0;
    while (int'(state_a) != target && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (int'(state_a) != target) begin
      failures++;
      $display("[TB] FAIL %s: timeout with state %0d, expected %0d", name, state_a, target);
    end
  endtask

  task automatic asyncReset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    checkResetValues(tag);
    @(negedge clk) reset = 1'b0;
  endtask

  // One filter sample per reference period, changed just after the reference edge.
  task automatic applyStimulus(input logic [4:0] value, input logic [4:0] thresh, input bit pulse);
    @(posedge clk_ref);
    #1;
    filter_out  = value;
    lock_thresh = thresh;
    if (pulse) pulseStart();
    repeat (6) @(negedge clk);
  endtask

  bit         hist[$];
  int         mode;
  logic [4:0] rv, rth;
  bit         want_good;

  function automatic bit tailAll(input int n, input bit val);
    if (hist.size() < n) return 1'b0;
    for (int i = hist.size() - n; i < hist.size(); i++)
      if (hist[i] != val) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    #900000;
    failures++;
    $display("[TB] FAIL watchdog: time limit reached, state %0d", state_a);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $fatal(1, "[TB] time limit");
  end

  initial begin
    reset       = 1'b0;
    start       = 1'b0;
    filter_out  = 5'd31;
    filter_sign = 1'b0;
    lock_thresh = 5'd3;
    alpha_acq   = 5'($urandom_range(1, 31));
    beta_acq    = 5'($urandom_range(1, 31));
    alpha_trk   = alpha_acq ^ 5'd21;
    beta_trk    = beta_acq ^ 5'd10;
    #1 reset = 1'b1;
    #20;
    checkResetValues("por");
    @(negedge clk) reset = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("idle_state", int'(state_a), 0);
    checkOutput("idle_pll_rst", int'(pll_rst_a), 1);

    trials_a.delete();
    trials_b.delete();
    pulseStart();
    checkOutput("start_state", int'(state_a), 1);
    checkOutput("start_offset", int'(off_a), 16);
    waitState(2, 100, "enter_cal_meas");
    pulseStart();
    waitState(3, 4000, "cal_to_acq");
    checkOutput("final_offset", int'(off_a), sarStep(1'b1, 5));
    checkOutput("cal_done", int'(cal_done_a), 1);
    checkOutput("acq_pll_rst", int'(pll_rst_a), 0);
    checkOutput("acq_alpha", int'(alpha_a), int'(alpha_acq));
    checkOutput("acq_beta", int'(beta_a), int'(beta_acq));
    checkOutput("acq_locked", int'(locked_a), 0);
    checkOutput("inv_final_offset", int'(off_b), sarStep(1'b0, 5));
    checkOutput("inv_cal_done", int'(cal_done_b), 1);
    checkOutput("trial_count", trials_a.size(), 5);
    checkOutput("inv_trial_count", trials_b.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < trials_a.size())
        checkOutput($sformatf("trial_a%0d", i), trials_a[i], sarStep(1'b1, i));
      if (i < trials_b.size())
        checkOutput($sformatf("trial_b%0d", i), trials_b[i], sarStep(1'b0, i));
    end

    for (int i = 0; i < 7; i++) addVec(2, 3, 1'b0, 3, 1'b0);
    addVec(9, 3, 1'b0, 3, 1'b0);
    for (int i = 0; i < 7; i++) addVec(2, 3, (i == 3), 3, 1'b0);
    addVec(2, 3, 1'b0, 4, 1'b1);
    for (int i = 0; i < 3; i++) addVec(9, 3, 1'b0, 4, 1'b1);
    addVec(2, 3, 1'b1, 4, 1'b1);
    for (int i = 0; i < 3; i++) addVec(9, 3, 1'b0, 4, 1'b1);
    addVec(9, 3, 1'b0, 3, 1'b0);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].fo, vecs[i].th, vecs[i].pulse);
      checkLoop($sformatf("vec%0d", i), vecs[i].exp_state, vecs[i].exp_locked);
    end
    checkOutput("inv_tracks_too", int'(state_b), 3);

    mode = 3;
    hist.delete();
    for (int k = 0; k < 150; k++) begin
      rth       = 5'($urandom_range(2, 29));
      want_good = (mode == 3) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 4);
      rv        = want_good ? 5'($urandom_range(0, int'(rth)))
                            : 5'($urandom_range(int'(rth) + 1, 31));
      applyStimulus(rv, rth, ($urandom_range(0, 15) == 0));
      hist.push_back(rv <= rth);
      if (mode == 3 && tailAll(LOCK_CNT, 1'b1)) begin
        mode = 4;
        hist.delete();
      end else if (mode == 4 && tailAll(LOSS_CNT, 1'b0)) begin
        mode = 3;
        hist.delete();
      end
      checkLoop($sformatf("rnd%0d", k), mode, (mode == 4));
    end

    repeat ($urandom_range(1, 30)) @(negedge clk);
    asyncReset("rst_loop");
    filter_out = 5'd31;

    pulseStart();
    waitState(2, 100, "enter_cal_meas2");
    repeat ($urandom_range(5, 200)) @(negedge clk);
    asyncReset("rst_meas");
    repeat (10) @(negedge clk);
    checkOutput("idle_after_reset", int'(state_a), 0);
    checkOutput("idle_after_reset_pll_rst", int'(pll_rst_a), 1);

    ref_half = 500;
    fb_force = 1'b1;
    repeat (3) @(posedge clk_ref);
    @(negedge clk);
    pulseStart();
    waitState(2, 100, "sat_enter_meas");
    waitState(1, 4000, "sat_decision");
    checkOutput("sat_bit_cleared", int'(off_a), 8);
    checkOutput("sat_inv_bit_kept", int'(off_b), 24);
    asyncReset("rst_sat");
    fb_force = 1'b0;
    ref_half = REF_NOM / 2;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
